// File: rtl/beep_sequencer.sv
// Turns key/alarm event pulses into an enveloped square-wave tone on the buzzer pin.
// All outputs are registered; requests sampled at edge N take effect in the cycle after edge N.
module beep_sequencer #(
  parameter int TONE_HALF  = 6000,
  parameter int KEY_LEN    = 1_200_000,
  parameter int BEEP_LEN   = 4_800_000,
  parameter int GAP_LEN    = 2_400_000,
  parameter int ALARM_REPS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic key_req,
  input  logic alarm_req,
  input  logic alarm_stop,
  input  logic enable,
  output logic buzzer,
  output logic busy,
  output logic done
);

  localparam int DMAX0  = (KEY_LEN > BEEP_LEN) ? KEY_LEN : BEEP_LEN;
  localparam int DMAX   = (DMAX0 > GAP_LEN) ? DMAX0 : GAP_LEN;
  localparam int DUR_W  = ($clog2(DMAX + 1) > 23) ? $clog2(DMAX + 1) : 23;
  localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  localparam logic [DUR_W-1:0]  KEY_LAST  = DUR_W'(KEY_LEN - 1);
  localparam logic [DUR_W-1:0]  BEEP_LAST = DUR_W'(BEEP_LEN - 1);
  localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_LEN - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
  localparam logic [3:0]        REPS      = 4'(ALARM_REPS);

  typedef enum logic [1:0] {IDLE, KEY, ATONE, AGAP} state_t;

  state_t            state, state_nxt;
  logic [DUR_W-1:0]  dur_cnt, dur_nxt;
  logic [TONE_W-1:0] tone_cnt, tone_nxt;
  logic              phase, phase_nxt;
  logic [3:0]        rep_cnt, rep_nxt;
  logic              done_nxt;
  logic              buzzer_nxt;
  logic              start_tone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      tone_cnt <= '0;
      phase    <= 1'b0;
      rep_cnt  <= '0;
      buzzer   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      dur_cnt  <= dur_nxt;
      tone_cnt <= tone_nxt;
      phase    <= phase_nxt;
      rep_cnt  <= rep_nxt;
      buzzer   <= buzzer_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    dur_nxt    = dur_cnt + 1'b1;
    rep_nxt    = rep_cnt;
    done_nxt   = 1'b0;
    start_tone = 1'b0;
    if (tone_cnt == TONE_LAST) begin
      tone_nxt  = '0;
      phase_nxt = ~phase;
    end else begin
      tone_nxt  = tone_cnt + 1'b1;
      phase_nxt = phase;
    end

    case (state)
      IDLE: begin
        if (alarm_req && !alarm_stop) begin
          state_nxt  = ATONE;
          rep_nxt    = 4'd1;
          start_tone = 1'b1;
        end else if (key_req) begin
          state_nxt  = KEY;
          start_tone = 1'b1;
        end
      end
      KEY: begin
        if (alarm_req) begin
          state_nxt  = ATONE;
          rep_nxt    = 4'd1;
          start_tone = 1'b1;
        end else if (key_req) begin
          dur_nxt = '0;  // retrigger extends the click; tone phase keeps running
        end else if (dur_cnt == KEY_LAST) begin
          state_nxt = IDLE;
        end
      end
      ATONE: begin
        if (alarm_stop) begin
          state_nxt = IDLE;
        end else if (dur_cnt == BEEP_LAST) begin
          dur_nxt = '0;
          if (rep_cnt == REPS) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = AGAP;
          end
        end
      end
      AGAP: begin
        if (alarm_stop) begin
          state_nxt = IDLE;
        end else if (dur_cnt == GAP_LAST) begin
          state_nxt  = ATONE;
          rep_nxt    = rep_cnt + 1'b1;
          start_tone = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start_tone) begin
      dur_nxt   = '0;
      tone_nxt  = '0;
      phase_nxt = 1'b1;
    end
    if (state_nxt == IDLE) begin
      dur_nxt   = '0;
      tone_nxt  = '0;
      phase_nxt = 1'b0;
      rep_nxt   = '0;
    end

    buzzer_nxt = ((state_nxt == KEY) || (state_nxt == ATONE)) && phase_nxt && enable;
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with shortened timing parameters.
module tb_beep_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic key_req, alarm_req, alarm_stop, enable;
  logic buzzer, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [99:0] key_v, alarm_v, stop_v;
  logic        en_v;
  logic [99:0] obs_busy, obs_buzz, obs_done;
  logic [99:0] exp_busy, exp_buzz, exp_done;

  beep_sequencer #(
    .TONE_HALF(2), .KEY_LEN(8), .BEEP_LEN(10), .GAP_LEN(6), .ALARM_REPS(3)
  ) dut (
    .clk(clk), .rst(rst), .key_req(key_req), .alarm_req(alarm_req),
    .alarm_stop(alarm_stop), .enable(enable),
    .buzzer(buzzer), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [99:0] rng(input int lo, input int hi);
    logic [99:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // TONE_HALF=2: phase 1,1,0,0 repeating from the burst start
  function automatic logic [99:0] tone(input int s, input int len);
    logic [99:0] m = '0;
    for (int i = 0; i < len; i++)
      if (((i / 2) % 2) == 0) m[s + i] = 1'b1;
    return m;
  endfunction

  task automatic clr_stim();
    key_v = '0; alarm_v = '0; stop_v = '0; en_v = 1'b1;
  endtask

  // Entered just after a rising edge; cycle c inputs are applied during cycle c.
  task automatic run(input int n);
    obs_busy = '0; obs_buzz = '0; obs_done = '0;
    for (int c = 0; c < n; c++) begin
      key_req = key_v[c]; alarm_req = alarm_v[c]; alarm_stop = stop_v[c]; enable = en_v;
      @(negedge clk);
      obs_busy[c] = busy; obs_buzz[c] = buzzer; obs_done[c] = done;
      @(posedge clk); #1;
    end
    key_req = 1'b0; alarm_req = 1'b0; alarm_stop = 1'b0; enable = 1'b1;
  endtask

  task automatic check_run(input string name);
    chk({name, "_busy"}, obs_busy, exp_busy);
    chk({name, "_buzzer"}, obs_buzz, exp_buzz);
    chk({name, "_done"}, obs_done, exp_done);
  endtask

  initial begin
    rst = 1'b1; key_req = 1'b0; alarm_req = 1'b0; alarm_stop = 1'b0; enable = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", {97'd0, buzzer, busy, done}, 100'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // single key click
    clr_stim(); key_v[0] = 1'b1;
    run(14);
    exp_busy = rng(1, 8); exp_buzz = tone(1, 8); exp_done = '0;
    check_run("key");

    // full alarm
    clr_stim(); alarm_v[0] = 1'b1;
    run(48);
    exp_busy = rng(1, 42);
    exp_buzz = tone(1, 10) | tone(17, 10) | tone(33, 10);
    exp_done = '0; exp_done[43] = 1'b1;
    check_run("alarm");

    // stop in second gap, then a fresh alarm
    clr_stim(); alarm_v[0] = 1'b1; stop_v[28] = 1'b1; alarm_v[31] = 1'b1;
    run(80);
    exp_busy = rng(1, 28) | rng(32, 73);
    exp_buzz = tone(1, 10) | tone(17, 10) | tone(32, 10) | tone(48, 10) | tone(64, 10);
    exp_done = '0; exp_done[74] = 1'b1;
    check_run("stop_then_alarm");

    // stop and alarm together in IDLE: stop wins; with key_req also high a click starts
    clr_stim(); alarm_v[0] = 1'b1; stop_v[0] = 1'b1;
    alarm_v[4] = 1'b1; stop_v[4] = 1'b1; key_v[4] = 1'b1;
    run(16);
    exp_busy = rng(5, 12); exp_buzz = tone(5, 8); exp_done = '0;
    check_run("stop_wins");

    // key preempted by alarm; key and alarm requests ignored during alarm
    clr_stim(); key_v[0] = 1'b1; alarm_v[3] = 1'b1;
    key_v[8] = 1'b1; key_v[17] = 1'b1; key_v[22] = 1'b1; alarm_v[25] = 1'b1;
    run(50);
    exp_busy = rng(1, 45);
    exp_buzz = tone(1, 3) | tone(4, 10) | tone(20, 10) | tone(36, 10);
    exp_done = '0; exp_done[46] = 1'b1;
    check_run("preempt");

    // retrigger
    clr_stim(); key_v[0] = 1'b1; key_v[5] = 1'b1;
    run(16);
    exp_busy = rng(1, 13); exp_buzz = tone(1, 13); exp_done = '0;
    check_run("retrigger");

    // retrigger muted
    clr_stim(); key_v[0] = 1'b1; key_v[5] = 1'b1; en_v = 1'b0;
    run(16);
    exp_buzz = '0;
    check_run("muted");

    // async reset mid-ATONE
    alarm_req = 1'b1;
    @(posedge clk); #1;
    alarm_req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_buzzer", {99'd0, buzzer}, 100'd1);
    chk("pre_reset_busy", {99'd0, busy}, 100'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {97'd0, buzzer, busy, done}, 100'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    clr_stim(); key_v[0] = 1'b1;
    run(14);
    exp_busy = rng(1, 8); exp_buzz = tone(1, 8); exp_done = '0;
    check_run("key_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
